// File: rtl/vm_select_ctrl_if.sv
// Keypad-to-dispenser selection bus for vm_select_ctrl.
// The master side drives the raw keypad code and control strobes;
// the slave side is the selection controller.
interface vm_select_ctrl_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
);
    logic [ROW_W-1:0] row_in;
    logic [COL_W-1:0] col_in;
    logic             cancel;
    logic             dispense_ack;
    logic [ROW_W-1:0] row_out;
    logic [COL_W-1:0] col_out;
    logic             sel_valid;
    logic             busy;
    logic             err_range;
    logic             timeout;
    logic             done;

    modport master (
        output row_in, col_in, cancel, dispense_ack,
        input  row_out, col_out, sel_valid, busy, err_range, timeout, done
    );

    modport slave (
        input  row_in, col_in, cancel, dispense_ack,
        output row_out, col_out, sel_valid, busy, err_range, timeout, done
    );
endinterface

// File: rtl/vm_select_ctrl.sv
// Vending-machine selection stage: debounces a keypad row/column code,
// range-checks it against the slot grid and holds the accepted selection
// for the dispenser until ack, cancel or timeout, then waits for key release.
module vm_select_ctrl #(
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    parameter int MAX_ROW     = 8,
    parameter int MAX_COL     = 8,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            reset,
    vm_select_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] cand_row_q, cand_row_d;
    logic [COL_W-1:0] cand_col_q, cand_col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ROW_W-1:0] row_out_q, row_out_d;
    logic [COL_W-1:0] col_out_q, col_out_d;
    logic             sel_valid_q, sel_valid_d;
    logic             busy_q, busy_d;
    logic             err_range_q, err_range_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;

    logic             key_nonzero_s;
    logic             key_in_range_s;
    logic             key_match_s;
    logic [CNT_W-1:0] cnt_inc_s;
    state_t           start_state_s;
    logic             start_err_s;

    assign key_nonzero_s  = (bus.row_in != '0) && (bus.col_in != '0);
    assign key_in_range_s = (bus.row_in <= ROW_W'(MAX_ROW)) && (bus.col_in <= COL_W'(MAX_COL));
    assign key_match_s    = (bus.row_in == cand_row_q) && (bus.col_in == cand_col_q);
    assign cnt_inc_s      = cnt_q + CNT_W'(1);

    // Fresh-code check shared by IDLE and a code change during DEBOUNCE.
    always_comb begin
        start_state_s = ST_IDLE;
        start_err_s   = 1'b0;
        if (!key_nonzero_s) begin
            start_state_s = ST_IDLE;
        end else if (!key_in_range_s) begin
            start_state_s = ST_RELEASE;
            start_err_s   = 1'b1;
        end else if (STABLE_CYC == 1) begin
            start_state_s = ST_HOLD;
        end else begin
            start_state_s = ST_DEBOUNCE;
        end
    end

    // Next-state and next-output logic for the selection FSM.
    always_comb begin
        state_d     = state_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        row_out_d   = row_out_q;
        col_out_d   = col_out_q;
        err_range_d = 1'b0;
        timeout_d   = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Candidate and counters are loaded unconditionally; they only
                // matter when the start check leaves IDLE.
                state_d     = start_state_s;
                err_range_d = start_err_s;
                cand_row_d  = bus.row_in;
                cand_col_d  = bus.col_in;
                cnt_d       = CNT_W'(1);
                timer_d     = '0;
                if (start_state_s == ST_HOLD) begin
                    row_out_d = bus.row_in;
                    col_out_d = bus.col_in;
                end else begin
                    row_out_d = '0;
                    col_out_d = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (bus.cancel) begin
                    state_d = ST_IDLE;
                end else if (key_match_s) begin
                    if (cnt_inc_s == CNT_W'(STABLE_CYC)) begin
                        state_d   = ST_HOLD;
                        row_out_d = cand_row_q;
                        col_out_d = cand_col_q;
                        timer_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else if (!key_nonzero_s) begin
                    state_d = ST_IDLE;
                end else begin
                    // A different code restarts the debounce from scratch.
                    state_d     = start_state_s;
                    err_range_d = start_err_s;
                    cand_row_d  = bus.row_in;
                    cand_col_d  = bus.col_in;
                    cnt_d       = CNT_W'(1);
                    timer_d     = '0;
                    if (start_state_s == ST_HOLD) begin
                        row_out_d = bus.row_in;
                        col_out_d = bus.col_in;
                    end else begin
                        row_out_d = '0;
                        col_out_d = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.cancel) begin
                    state_d   = ST_RELEASE;
                    row_out_d = '0;
                    col_out_d = '0;
                end else if (bus.dispense_ack) begin
                    state_d   = ST_RELEASE;
                    done_d    = 1'b1;
                    row_out_d = '0;
                    col_out_d = '0;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                    row_out_d = '0;
                    col_out_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RELEASE: begin
                if ((bus.row_in == '0) && (bus.col_in == '0)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                row_out_d = '0;
                col_out_d = '0;
            end
        endcase

        sel_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered-output flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cand_row_q  <= '0;
            cand_col_q  <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            row_out_q   <= '0;
            col_out_q   <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_range_q <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            row_out_q   <= row_out_d;
            col_out_q   <= col_out_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            err_range_q <= err_range_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
        end
    end

    assign bus.row_out   = row_out_q;
    assign bus.col_out   = col_out_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err_range = err_range_q;
    assign bus.timeout   = timeout_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_vm_select_ctrl.sv
// Bench for vm_select_ctrl: three instances (default, short timeout,
// single-cycle debounce) share one stimulus stream. Directed steps carry
// fixed expectations; every cycle all instances are also compared against
// a behavioural model, followed by a randomized phase.
module tb_vm_select_ctrl;
    localparam int P_IDLE = 0;
    localparam int P_DEB  = 1;
    localparam int P_HOLD = 2;
    localparam int P_REL  = 3;
    localparam int ST_P [3] = '{4, 4, 1};
    localparam int TO_P [3] = '{255, 5, 5};

    logic clk;
    logic reset;

    vm_select_ctrl_if #(.ROW_W(4), .COL_W(4)) if_a ();
    vm_select_ctrl_if #(.ROW_W(4), .COL_W(4)) if_b ();
    vm_select_ctrl_if #(.ROW_W(4), .COL_W(4)) if_c ();

    vm_select_ctrl #(.STABLE_CYC(4), .TIMEOUT_CYC(255)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    vm_select_ctrl #(.STABLE_CYC(4), .TIMEOUT_CYC(5))   dut_b (.clk(clk), .reset(reset), .bus(if_b));
    vm_select_ctrl #(.STABLE_CYC(1), .TIMEOUT_CYC(5))   dut_c (.clk(clk), .reset(reset), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [3:0] cur_r, cur_c;
    bit         cur_cn, cur_ak;

    // behavioural model state per instance
    int         m_ph  [3];
    int         m_cnt [3];
    int         m_age [3];
    logic [3:0] m_cr  [3];
    logic [3:0] m_cc  [3];
    logic [3:0] m_row [3];
    logic [3:0] m_col [3];
    bit         m_err [3];
    bit         m_to  [3];
    bit         m_done[3];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_ph[d] = P_IDLE; m_cnt[d] = 0; m_age[d] = 0;
            m_cr[d] = 4'd0; m_cc[d] = 4'd0; m_row[d] = 4'd0; m_col[d] = 4'd0;
            m_err[d] = 1'b0; m_to[d] = 1'b0; m_done[d] = 1'b0;
        end
    endtask

    task automatic enter_hold(input int d, input logic [3:0] r, input logic [3:0] c);
        m_ph[d] = P_HOLD; m_row[d] = r; m_col[d] = c; m_age[d] = 0;
    endtask

    task automatic try_start(input int d, input logic [3:0] r, input logic [3:0] c);
        if (r == 4'd0 || c == 4'd0) begin
            m_ph[d] = P_IDLE;
        end else if (r > 4'd8 || c > 4'd8) begin
            m_err[d] = 1'b1;
            m_ph[d]  = P_REL;
        end else begin
            m_cr[d] = r; m_cc[d] = c; m_cnt[d] = 1;
            if (ST_P[d] == 1) enter_hold(d, r, c);
            else m_ph[d] = P_DEB;
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] c, input bit cn, input bit ak);
        for (int d = 0; d < 3; d++) begin
            m_err[d] = 1'b0; m_to[d] = 1'b0; m_done[d] = 1'b0;
            case (m_ph[d])
                P_IDLE: try_start(d, r, c);
                P_DEB: begin
                    if (cn) m_ph[d] = P_IDLE;
                    else if (r == m_cr[d] && c == m_cc[d]) begin
                        m_cnt[d]++;
                        if (m_cnt[d] == ST_P[d]) enter_hold(d, r, c);
                    end else if (r == 4'd0 || c == 4'd0) m_ph[d] = P_IDLE;
                    else try_start(d, r, c);
                end
                P_HOLD: begin
                    if (cn) m_ph[d] = P_REL;
                    else if (ak) begin m_done[d] = 1'b1; m_ph[d] = P_REL; end
                    else if (m_age[d] + 1 == TO_P[d]) begin m_to[d] = 1'b1; m_ph[d] = P_REL; end
                    else m_age[d]++;
                end
                default: if (r == 4'd0 && c == 4'd0) m_ph[d] = P_IDLE;
            endcase
        end
    endtask

    function automatic logic [12:0] exp_vec(input int d);
        logic hold;
        hold = (m_ph[d] == P_HOLD);
        return {hold ? m_row[d] : 4'd0, hold ? m_col[d] : 4'd0, hold,
                m_ph[d] != P_IDLE, m_err[d], m_to[d], m_done[d]};
    endfunction

    function automatic logic [12:0] get_obs(input int d);
        case (d)
            0: return {if_a.row_out, if_a.col_out, if_a.sel_valid, if_a.busy, if_a.err_range, if_a.timeout, if_a.done};
            1: return {if_b.row_out, if_b.col_out, if_b.sel_valid, if_b.busy, if_b.err_range, if_b.timeout, if_b.done};
            default: return {if_c.row_out, if_c.col_out, if_c.sel_valid, if_c.busy, if_c.err_range, if_c.timeout, if_c.done};
        endcase
    endfunction

    // vector layout: row,col,sel_valid,busy,err_range,timeout,done
    task automatic compare_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("model cyc%0d inst%0d", cyc, d), 32'(get_obs(d)), 32'(exp_vec(d)));
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] c, input bit cn, input bit ak);
        cur_r = r; cur_c = c; cur_cn = cn; cur_ak = ak;
        if_a.row_in = r; if_a.col_in = c; if_a.cancel = cn; if_a.dispense_ack = ak;
        if_b.row_in = r; if_b.col_in = c; if_b.cancel = cn; if_b.dispense_ack = ak;
        if_c.row_in = r; if_c.col_in = c; if_c.cancel = cn; if_c.dispense_ack = ak;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!reset) model_reset();
            else model_step(cur_r, cur_c, cur_cn, cur_ak);
            #1;
            compare_all();
            cyc++;
        end
    endtask

    initial begin
        int hold_left;
        logic [3:0] rr, cc;
        reset = 1'b0;
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        model_reset();
        #3;
        compare_all();
        chk("reset.busy", 32'(if_a.busy), 32'd0);
        tick(2);
        reset = 1'b1;

        // basic accept and ack
        drive(4'd3, 4'd5, 1'b0, 1'b0);
        tick(3);
        chk("t1.sv_before", 32'(if_a.sel_valid), 32'd0);
        chk("t1.busy_deb", 32'(if_a.busy), 32'd1);
        tick(1);
        chk("t1.sv", 32'(if_a.sel_valid), 32'd1);
        chk("t1.row", 32'(if_a.row_out), 32'd3);
        chk("t1.col", 32'(if_a.col_out), 32'd5);
        tick(2);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(4);
        chk("t1.sv_held", 32'(if_a.sel_valid), 32'd1);
        drive(4'd0, 4'd0, 1'b0, 1'b1);
        tick(1);
        chk("t1.done", 32'(if_a.done), 32'd1);
        chk("t1.sv_off", 32'(if_a.sel_valid), 32'd0);
        chk("t1.row_off", 32'(if_a.row_out), 32'd0);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(1);
        chk("t1.done_off", 32'(if_a.done), 32'd0);
        chk("t1.idle", 32'(if_a.busy), 32'd0);

        // bounce: 3/5 for two cycles then 3/6
        drive(4'd3, 4'd5, 1'b0, 1'b0);
        tick(2);
        drive(4'd3, 4'd6, 1'b0, 1'b0);
        tick(3);
        chk("t2.sv_early", 32'(if_a.sel_valid), 32'd0);
        tick(1);
        chk("t2.sv", 32'(if_a.sel_valid), 32'd1);
        chk("t2.col", 32'(if_a.col_out), 32'd6);
        drive(4'd0, 4'd0, 1'b1, 1'b0);
        tick(1);
        chk("t2.cancel_rel", 32'(if_a.busy), 32'd1);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(1);
        drive(4'd4, 4'd4, 1'b0, 1'b0);
        tick(2);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(1);
        chk("t2.short_idle", 32'(if_a.busy), 32'd0);
        chk("t2.short_sv", 32'(if_a.sel_valid), 32'd0);

        // range check
        drive(4'd9, 4'd2, 1'b0, 1'b0);
        tick(1);
        chk("t3.err", 32'(if_a.err_range), 32'd1);
        chk("t3.busy", 32'(if_a.busy), 32'd1);
        tick(1);
        chk("t3.err_pulse", 32'(if_a.err_range), 32'd0);
        chk("t3.busy_rel", 32'(if_a.busy), 32'd1);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(1);
        chk("t3.busy_idle", 32'(if_a.busy), 32'd0);
        drive(4'd8, 4'd8, 1'b0, 1'b0);
        tick(4);
        chk("t3.edge_sv", 32'(if_a.sel_valid), 32'd1);
        chk("t3.edge_row", 32'(if_a.row_out), 32'd8);
        drive(4'd0, 4'd0, 1'b0, 1'b1);
        tick(1);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(1);

        // timeout on the short-timeout instance
        drive(4'd2, 4'd7, 1'b0, 1'b0);
        tick(4);
        chk("t4.b_sv", 32'(if_b.sel_valid), 32'd1);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(4);
        chk("t4.b_sv5", 32'(if_b.sel_valid), 32'd1);
        chk("t4.b_to_early", 32'(if_b.timeout), 32'd0);
        tick(1);
        chk("t4.b_to", 32'(if_b.timeout), 32'd1);
        chk("t4.b_sv_off", 32'(if_b.sel_valid), 32'd0);
        tick(1);
        chk("t4.b_to_pulse", 32'(if_b.timeout), 32'd0);
        drive(4'd0, 4'd0, 1'b0, 1'b1);
        tick(1);
        drive(4'd2, 4'd7, 1'b0, 1'b0);
        tick(4);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(4);
        drive(4'd0, 4'd0, 1'b0, 1'b1);
        tick(1);
        chk("t4.b_ack_done", 32'(if_b.done), 32'd1);
        chk("t4.b_ack_to", 32'(if_b.timeout), 32'd0);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(1);

        // cancel in debounce, cancel+ack in hold
        drive(4'd2, 4'd2, 1'b0, 1'b0);
        tick(2);
        drive(4'd2, 4'd2, 1'b1, 1'b0);
        tick(1);
        chk("t5.deb_cancel", 32'(if_a.busy), 32'd0);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(1);
        drive(4'd5, 4'd5, 1'b0, 1'b0);
        tick(4);
        chk("t5.hold", 32'(if_a.sel_valid), 32'd1);
        drive(4'd5, 4'd5, 1'b1, 1'b1);
        tick(1);
        chk("t5.cx_sv", 32'(if_a.sel_valid), 32'd0);
        chk("t5.cx_done", 32'(if_a.done), 32'd0);
        chk("t5.cx_row", 32'(if_a.row_out), 32'd0);
        drive(4'd5, 4'd5, 1'b0, 1'b0);
        tick(2);
        chk("t5.rel_busy", 32'(if_a.busy), 32'd1);
        chk("t5.rel_sv", 32'(if_a.sel_valid), 32'd0);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(1);
        chk("t5.idle", 32'(if_a.busy), 32'd0);

        // async reset mid-hold
        drive(4'd3, 4'd1, 1'b0, 1'b0);
        tick(4);
        chk("t6.row", 32'(if_a.row_out), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("t6.rst_row", 32'(if_a.row_out), 32'd0);
        chk("t6.rst_sv", 32'(if_a.sel_valid), 32'd0);
        #1;
        reset = 1'b1;
        tick(1);
        chk("t6.redeb", 32'(if_a.sel_valid), 32'd0);
        chk("t6.redeb_busy", 32'(if_a.busy), 32'd1);
        chk("t6.c_sv", 32'(if_c.sel_valid), 32'd1);
        tick(2);
        chk("t6.redeb3", 32'(if_a.sel_valid), 32'd0);
        tick(1);
        chk("t6.redeb_sv", 32'(if_a.sel_valid), 32'd1);
        drive(4'd0, 4'd0, 1'b0, 1'b1);
        tick(1);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        tick(1);

        // randomized stream against the model
        hold_left = 0;
        rr = 4'd0;
        cc = 4'd0;
        for (int i = 0; i < 800; i++) begin
            if (hold_left == 0) begin
                if ($urandom_range(0, 9) < 3) begin
                    rr = 4'd0; cc = 4'd0;
                end else begin
                    rr = 4'($urandom_range(0, 10));
                    cc = 4'($urandom_range(0, 10));
                end
                hold_left = $urandom_range(1, 8);
            end
            hold_left--;
            drive(rr, cc, $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
            tick(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vm_select_ctrl.md
# vm_select_ctrl

Parametrised successor to the vending-machine idle/selection stage. Accepts raw keypad row/column codes and debounces them over a configurable number of cycles. It range-checks the codes against the machine's slot grid and holds a validated selection for the dispenser until acknowledged, cancelled or timed out. It then requires the keypad to return to zero before it accepts a new selection. It sits between the keypad scanner and the dispense controller.

## Interface
Parameters:
- ROW_W, 4, width of row code
- COL_W, 4, width of column code
- MAX_ROW, 8, highest legal row code (legal rows are 1..MAX_ROW); must be < 2^ROW_W
- MAX_COL, 8, highest legal column code (legal columns are 1..MAX_COL); must be < 2^COL_W
- STABLE_CYC, 4, consecutive identical samples required to accept a selection; must be ≥1
- TIMEOUT_CYC, 255, maximum cycles sel_valid is held without ack; must be ≥2

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- row_in  in  ROW_W  raw row code; 0 means no key
- col_in  in  COL_W  raw column code; 0 means no key
- cancel  in  1  user cancel, level-sampled
- dispense_ack  in  1  dispenser has taken the selection
- row_out  out  ROW_W  accepted row; 0 when no selection is held
- col_out  out  COL_W  accepted column; 0 when no selection is held
- sel_valid  out  1  high while a selection is held
- busy  out  1  high in any state other than IDLE
- err_range  out  1  one-cycle pulse on an out-of-range code
- timeout  out  1  one-cycle pulse when the hold expires
- done  out  1  one-cycle pulse when dispense_ack is accepted

## Operation
- All outputs are registered. While reset=0, the block is in IDLE and every output is 0.
- A code is nonzero when row_in≠0 and col_in≠0. A code is in range when row_in≤MAX_ROW and col_in≤MAX_COL.
- IDLE:
  - Nonzero and in range: capture the candidate, set cnt=1, go to DEBOUNCE. If STABLE_CYC=1, go straight to HOLD instead.
  - Nonzero and out of range: pulse err_range, go to RELEASE.
  - Otherwise stay in IDLE. cancel has no effect in IDLE.
- DEBOUNCE:
  - cancel: go to IDLE.
  - Input equals the candidate: cnt+1. When cnt+1 = STABLE_CYC, load row_out/col_out, set sel_valid=1, clear the hold timer, go to HOLD.
  - Input is zero (either field 0): go to IDLE.
  - Input is a different nonzero code: re-run the IDLE check with that code (restart with cnt=1, or err_range and RELEASE).
- HOLD: sel_valid=1 and outputs stay stable. The hold timer increments each cycle. Priority, highest first:
  - cancel: clear outputs, go to RELEASE. No done or timeout pulse.
  - dispense_ack: pulse done, clear outputs, go to RELEASE.
  - Timer = TIMEOUT_CYC−1: pulse timeout, clear outputs, go to RELEASE.
- RELEASE: outputs are 0. Go to IDLE when row_in=0 and col_in=0. Until then, a held or changed key is ignored.
- Counter widths are $clog2(STABLE_CYC+1) and $clog2(TIMEOUT_CYC+1). Neither counter can wrap, because each is cleared on state entry.
- Inputs are treated as synchronous to clk. Synchronisation is the scanner's responsibility.

## Timing
- Acceptance latency: a code first sampled at edge k, and stable, gives sel_valid=1 after edge k+STABLE_CYC−1.
- row_out, col_out and sel_valid change on the same edge.
- sel_valid lasts at most TIMEOUT_CYC cycles. The timeout pulse coincides with the edge that drops sel_valid.
- dispense_ack sampled at edge n gives sel_valid=0 and done=1 after edge n. done is 0 after edge n+1.
- If dispense_ack and timer expiry occur in the same cycle, ack wins: done=1, timeout=0.
- If cancel and dispense_ack occur in the same cycle, cancel wins: done=0.
- Asserting reset in any state immediately forces IDLE with all outputs 0. Deassertion takes effect at the next edge.
- Minimum cycle from one selection to the next: the key must read zero for at least 1 sampled cycle in RELEASE before IDLE can capture again.

## Test plan
- Default parameters, row=3/col=5 held for 6 cycles from edge 0 → sel_valid=1 and row_out=3/col_out=5 after edge 3; dispense_ack at edge 10 → done pulse, outputs 0 after edge 10.
- Bounce: row=3/col=5 for 2 cycles, then row=3/col=6 for 4 cycles → sel_valid only for 3/6, asserted 3 edges after 3/6 first appears. Also: a 2-cycle press → no sel_valid, back to IDLE.
- Range: row=9/col=2 → err_range one-cycle pulse, busy=1 until both inputs are 0. Also: row=8/col=8 → accepted.
- Timeout with TIMEOUT_CYC=5: no ack → sel_valid high for exactly 5 cycles, then timeout pulse. Also: ack in the 5th cycle → done=1, timeout=0.
- Cancel in DEBOUNCE → IDLE with no outputs. Also: cancel together with ack in HOLD → outputs cleared, done=0, RELEASE until the keys are released.
- Reset=0 asserted mid-HOLD with row_out=3 → all outputs 0 asynchronously. After release, a held key is re-debounced from cnt=1. STABLE_CYC=1 variant → sel_valid after the first edge.
